// File: rtl/regbus_arbiter.sv
// Two-master round-robin arbiter for a word-addressed register bus, with a
// watchdog that force-completes accesses the slave never acknowledges.
module regbus_arbiter #(
  parameter int          ADDR_BITS      = 20,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic                 m0_en_i,
  input  logic                 m0_wr_i,
  input  logic [3:0]           m0_wstrb_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  input  logic [ADDR_BITS-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  input  logic                 m1_en_i,
  input  logic                 m1_wr_i,
  input  logic [3:0]           m1_wstrb_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic [ADDR_BITS-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic                 s_en_o,
  output logic                 s_wr_o,
  output logic [3:0]           s_wstrb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  output logic [1:0]           grant_o,
  output logic                 timeout_o,
  output logic [7:0]           timeout_count_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        last_grant;
  logic        owner;
  logic [15:0] wdog;
  logic        pick;

  // On a tie the master that did not win last time takes the bus.
  always_comb begin
    pick = m1_en_i;
    if (m0_en_i && m1_en_i) begin
      pick = ~last_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      wdog            <= '0;
      s_adr_o         <= '0;
      s_dat_o         <= '0;
      s_en_o          <= 1'b0;
      s_wr_o          <= 1'b0;
      s_wstrb_o       <= '0;
      m0_dat_o        <= '0;
      m1_dat_o        <= '0;
      m0_ack_o        <= 1'b0;
      m1_ack_o        <= 1'b0;
      grant_o         <= '0;
      timeout_o       <= 1'b0;
      timeout_count_o <= '0;
    end else begin
      m0_ack_o  <= 1'b0;
      m1_ack_o  <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          grant_o <= '0;
          if (m0_en_i || m1_en_i) begin
            owner      <= pick;
            last_grant <= pick;
            grant_o    <= pick ? 2'b10 : 2'b01;
            s_adr_o    <= pick ? m1_adr_i   : m0_adr_i;
            s_dat_o    <= pick ? m1_dat_i   : m0_dat_i;
            s_wr_o     <= pick ? m1_wr_i    : m0_wr_i;
            s_wstrb_o  <= pick ? m1_wstrb_i : m0_wstrb_i;
            s_en_o     <= 1'b1;
            wdog       <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (s_ack_i) begin
            if (owner) begin
              m1_dat_o <= s_dat_i;
              m1_ack_o <= 1'b1;
            end else begin
              m0_dat_o <= s_dat_i;
              m0_ack_o <= 1'b1;
            end
            s_en_o <= 1'b0;
            state  <= DONE;
          end else if (wdog == WDOG_LAST) begin
            if (owner) begin
              m1_dat_o <= TIMEOUT_DATA;
              m1_ack_o <= 1'b1;
            end else begin
              m0_dat_o <= TIMEOUT_DATA;
              m0_ack_o <= 1'b1;
            end
            s_en_o    <= 1'b0;
            timeout_o <= 1'b1;
            if (timeout_count_o != 8'hFF) begin
              timeout_count_o <= timeout_count_o + 8'd1;
            end
            state <= DONE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        DONE: begin
          grant_o <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
Shares one 20-bit word-addressed register bus (adr/dat/en/wr/wstrb/ack) between two masters, e.g. the board-manager UART bridge (m0) and a second control path (m1).
- Round-robin arbitration; one transaction in flight at a time.
- Registers the granted request onto the slave bus.
- A bus watchdog force-completes any access the slave never acknowledges, so a master cannot hang.

Parameters:
ADDR_BITS, 20, address width of masters and slave bus.
TIMEOUT_CYCLES, 255, maximum BUSY cycles before forced completion; legal range 2..65535.
TIMEOUT_DATA, 32'hDEADBEEF, read data returned on a timed-out access.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
m0_adr_i  in  ADDR_BITS  master 0 word address
m0_dat_i  in  32  master 0 write data
m0_en_i  in  1  master 0 request; held high until m0_ack_o
m0_wr_i  in  1  master 0 write (1) / read (0)
m0_wstrb_i  in  4  master 0 byte strobes
m0_dat_o  out  32  master 0 read data, held between completions
m0_ack_o  out  1  master 0 completion, 1-cycle pulse
m1_*  (same seven ports as m0_*, for master 1)
s_adr_o  out  ADDR_BITS  slave address
s_dat_o  out  32  slave write data
s_en_o  out  1  slave access enable
s_wr_o  out  1  slave write
s_wstrb_o  out  4  slave byte strobes
s_dat_i  in  32  slave read data, valid with s_ack_i
s_ack_i  in  1  slave acknowledge
grant_o  out  2  one-hot current owner; 00 when idle
timeout_o  out  1  1-cycle pulse on forced completion
timeout_count_o  out  8  saturating count of timeouts since reset

Behaviour:
- Reset (async, immediate): state=IDLE.
  - All s_* outputs, mX_ack_o, grant_o and timeout_o go to 0.
  - mX_dat_o and timeout_count_o go to 0.
  - last_grant=1, so m0 wins the first tie.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Sample m0_en_i/m1_en_i.
  - One requester: grant it.
  - Both requesting: grant the master other than last_grant.
  - On grant, register that master's adr/dat/wr/wstrb into s_*, set s_en_o=1, set grant_o and last_grant, clear wdog, go BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - s_* outputs hold stable; s_en_o=1.
  - If s_ack_i: capture s_dat_i into the owner's dat_o (reads and writes alike), s_en_o<=0, go DONE.
  - Else if wdog==TIMEOUT_CYCLES-1: owner dat_o<=TIMEOUT_DATA, s_en_o<=0, timeout_o<=1, timeout_count_o<=min(count+1,255), go DONE.
  - Else wdog<=wdog+1. wdog is 16 bits.
  - s_ack_i wins over simultaneous timeout expiry.
- DONE (exactly 1 cycle):
  - Owner mX_ack_o=1, grant_o still shows the owner, then return to IDLE.
  - m*_en_i is ignored in DONE; the owner's en is still high this cycle per protocol.
- Latency:
  - Request seen in IDLE at cycle 0 puts s_en_o high at cycle 1.
  - Slave ack at cycle k≥1 gives mX_ack_o at cycle k+1; IDLE at k+2.
  - New grant earliest at k+2, so s_en_o is next high at k+3.
- A forced completion gives at most TIMEOUT_CYCLES BUSY cycles.
- mX_dat_o changes only at that master's completions. Masters read it after ack, so it must not follow s_dat_i.
- The non-owner's ack_o and dat_o are untouched. s_ack_i outside BUSY is ignored.
- Request changes by the owner during BUSY are ignored, because s_* are registered at grant.
- Reset mid-BUSY: s_en_o drops asynchronously, no ack is issued to the owner, and a subsequent stray s_ack_i is ignored.
- Fairness: with both masters requesting continuously, grants strictly alternate m0,m1,m0...

Test Plan:
- m0 read 0x00010, slave acks 3 cycles after s_en_o with 0x12345678 -> s_adr_o=0x00010, s_en_o high 3 cycles; m0_ack_o 1 cycle later; m0_dat_o=0x12345678 held afterward; m1_ack_o never pulses.
- m0 and m1 raise en the same cycle after reset, slave acks each in 1 cycle -> m0 granted first, then m1; grant_o 01 then 10; s_en_o high periods separated by 2 idle cycles.
- Both masters issue back-to-back requests for 6 transactions -> grant order m0,m1,m0,m1,m0,m1; each m1 s_wstrb_o/s_dat_o matches m1 inputs.
- TIMEOUT_CYCLES=16, slave never acks m1 write -> s_en_o high exactly 16 cycles; then m1_ack_o and timeout_o pulse; m1_dat_o=0xDEADBEEF; timeout_count_o=1.
- TIMEOUT_CYCLES=16, s_ack_i on 16th BUSY cycle with 0xCAFEF00D -> normal completion; m0_dat_o=0xCAFEF00D; no timeout_o; count unchanged.
- rst asserted mid-BUSY for 2 cycles, slave acks during reset -> s_en_o drops without clock; no mX_ack_o; afterward grant_o=00, counts 0, and the next tie goes to m0.
